// File: rtl/circle_ctrl.sv
// Frame sequencer in front of the circle drawer: clears the screen, launches the
// drawer with latched parameters, and forwards its on-screen pixels to the VGA port.
module circle_ctrl #(
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter bit          CLEAR_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       done,
  output logic       busy,
  output logic       circ_start,
  output logic [2:0] circ_colour,
  output logic [7:0] circ_cx,
  output logic [6:0] circ_cy,
  output logic [7:0] circ_radius,
  input  logic       circ_done,
  input  logic       circ_plot,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_pcolour,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_DRAW   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);

  state_e     state_q, state_d;

  logic [7:0] clr_x_q, clr_x_d;
  logic [6:0] clr_y_q, clr_y_d;
  logic       clr_last;

  logic [2:0] par_col_q, par_col_d;
  logic [7:0] par_cx_q, par_cx_d;
  logic [6:0] par_cy_q, par_cy_d;
  logic [7:0] par_rad_q, par_rad_d;

  logic       vga_plot_q, vga_plot_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_col_q, vga_col_d;
  logic       done_q, done_d;

  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  endfunction

  // Clear counters hold the pixel currently on the VGA port during CLEAR.
  assign clr_last = (clr_x_q == X_LAST) && (clr_y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = CLEAR_EN ? S_CLEAR : S_LAUNCH;
      S_CLEAR:  if (clr_last) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_DRAW;
      S_DRAW:   if (circ_done) state_d = S_DONE;
      S_DONE:   if (!start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr_x_d    = clr_x_q;
    clr_y_d    = clr_y_q;
    par_col_d  = par_col_q;
    par_cx_d   = par_cx_q;
    par_cy_d   = par_cy_q;
    par_rad_d  = par_rad_q;
    vga_plot_d = 1'b0;
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    vga_col_d  = vga_col_q;
    done_d     = (state_d == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          par_col_d = colour;
          par_cx_d  = centre_x;
          par_cy_d  = centre_y;
          par_rad_d = radius;
          clr_x_d   = 8'd0;
          clr_y_d   = 7'd0;
        end
      end
      S_CLEAR: begin
        // y runs fastest; counters park on the last pixel instead of wrapping
        if (!clr_last) begin
          if (clr_y_q == Y_LAST) begin
            clr_y_d = 7'd0;
            clr_x_d = clr_x_q + 8'd1;
          end else begin
            clr_y_d = clr_y_q + 7'd1;
          end
        end
      end
      S_DRAW: begin
        // Coordinates always follow the drawer; only the strobe is clipped.
        vga_x_d    = circ_x;
        vga_y_d    = circ_y;
        vga_col_d  = circ_pcolour;
        vga_plot_d = circ_plot && on_screen(circ_x, circ_y);
      end
      default: ;
    endcase

    if (state_d == S_CLEAR) begin
      vga_plot_d = 1'b1;
      vga_x_d    = clr_x_d;
      vga_y_d    = clr_y_d;
      vga_col_d  = BG_COLOUR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_x_q    <= 8'd0;
      clr_y_q    <= 7'd0;
      par_col_q  <= 3'd0;
      par_cx_q   <= 8'd0;
      par_cy_q   <= 7'd0;
      par_rad_q  <= 8'd0;
      vga_plot_q <= 1'b0;
      vga_x_q    <= 8'd0;
      vga_y_q    <= 7'd0;
      vga_col_q  <= 3'd0;
      done_q     <= 1'b0;
    end else begin
      clr_x_q    <= clr_x_d;
      clr_y_q    <= clr_y_d;
      par_col_q  <= par_col_d;
      par_cx_q   <= par_cx_d;
      par_cy_q   <= par_cy_d;
      par_rad_q  <= par_rad_d;
      vga_plot_q <= vga_plot_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      vga_col_q  <= vga_col_d;
      done_q     <= done_d;
    end
  end

  assign busy        = (state_q == S_CLEAR) || (state_q == S_LAUNCH) || (state_q == S_DRAW);
  assign circ_start  = (state_q == S_LAUNCH) || (state_q == S_DRAW);
  assign done        = done_q;
  assign circ_colour = par_col_q;
  assign circ_cx     = par_cx_q;
  assign circ_cy     = par_cy_q;
  assign circ_radius = par_rad_q;
  assign vga_plot    = vga_plot_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_col_q;

endmodule

// File: tb/tb_circle_ctrl.sv
// Bench for circle_ctrl: a stub drawer drives the pixel side, and a second instance
// covers the build without the clear sweep.
module tb_circle_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst, start, start2;
  logic [2:0] colour;
  logic [7:0] centre_x, radius;
  logic [6:0] centre_y;
  logic       circ_done, circ_plot;
  logic [7:0] circ_x;
  logic [6:0] circ_y;
  logic [2:0] circ_pcolour;

  logic       done, busy, circ_start, vga_plot;
  logic [2:0] circ_colour, vga_colour;
  logic [7:0] circ_cx, circ_radius, vga_x;
  logic [6:0] circ_cy, vga_y;

  logic       done2, busy2, circ_start2, vga_plot2;
  logic [2:0] circ_colour2, vga_colour2;
  logic [7:0] circ_cx2, circ_radius2, vga_x2;
  logic [6:0] circ_cy2, vga_y2;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];

  logic [7:0] clip_x_tab [3] = '{8'd160, 8'd10, 8'd255};
  logic [6:0] clip_y_tab [3] = '{7'd10, 7'd120, 7'd127};

  circle_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .done(done), .busy(busy), .circ_start(circ_start),
    .circ_colour(circ_colour), .circ_cx(circ_cx), .circ_cy(circ_cy), .circ_radius(circ_radius),
    .circ_done(circ_done), .circ_plot(circ_plot), .circ_x(circ_x), .circ_y(circ_y),
    .circ_pcolour(circ_pcolour),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  circle_ctrl #(.CLEAR_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .done(done2), .busy(busy2), .circ_start(circ_start2),
    .circ_colour(circ_colour2), .circ_cx(circ_cx2), .circ_cy(circ_cy2), .circ_radius(circ_radius2),
    .circ_done(circ_done), .circ_plot(circ_plot), .circ_x(circ_x), .circ_y(circ_y),
    .circ_pcolour(circ_pcolour),
    .vga_plot(vga_plot2), .vga_x(vga_x2), .vga_y(vga_y2), .vga_colour(vga_colour2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic p, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic d);
    circ_plot    = p;
    circ_x       = x;
    circ_y       = y;
    circ_pcolour = c;
    circ_done    = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start2 = 1'b0;
    colour = 3'b111; centre_x = 8'd9; centre_y = 7'd9; radius = 8'd9;
    drive_pix(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    tick(); tick();
    tests_run++;
    if ({busy, done, circ_start, vga_plot} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy/done/start/plot=%b, expected 0000",
               {busy, done, circ_start, vga_plot});
    end
    tests_run++;
    if ({vga_x, vga_y, vga_colour} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_vga: got x=%0d y=%0d c=%0d, expected all 0", vga_x, vga_y, vga_colour);
    end
    tests_run++;
    if ({circ_colour, circ_cx, circ_cy, circ_radius} !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_params: got c=%0d cx=%0d cy=%0d r=%0d, expected all 0",
               circ_colour, circ_cx, circ_cy, circ_radius);
    end
    colour = 3'b011; centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40;
    rst = 1'b0;
    tick();
    colour = 3'b101; centre_x = 8'd1; centre_y = 7'd2; radius = 8'd3;
    tests_run++;
    if ({circ_colour, circ_cx, circ_cy, circ_radius} !== {3'b011, 8'd80, 7'd60, 8'd40}
        || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept_params: got c=%0d cx=%0d cy=%0d r=%0d busy=%b, expected 3 80 60 40 busy=1",
               circ_colour, circ_cx, circ_cy, circ_radius, busy);
    end
  endtask

  // Starts on the first CLEAR sample; start is dropped after pixel 500.
  task automatic test_clear_sweep();
    int n = 0;
    int bad = 0;
    int bad_idx = -1;
    int guard = 0;
    pix_t got, e, bad_got, bad_exp;
    bad_got = '0; bad_exp = '0;
    exp_q.delete();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        exp_q.push_back(pix_t'{8'(x), 7'(y), 3'b000});
    while (exp_q.size() != 0 && guard < 20000) begin
      got = {vga_x, vga_y, vga_colour};
      if (vga_plot === 1'b1 && circ_start === 1'b0 && busy === 1'b1) begin
        e = exp_q.pop_front();
        if (got !== e) begin
          if (bad == 0) begin bad_idx = n; bad_got = got; bad_exp = e; end
          bad++;
        end
        n++;
        if (n == 500) start = 1'b0;
      end else begin
        if (bad == 0) begin bad_idx = n; bad_got = got; bad_exp = exp_q[0]; end
        bad++;
      end
      tick();
      guard++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL clear_pixels: %0d bad cycles, first at pixel %0d got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
               bad, bad_idx, bad_got.x, bad_got.y, bad_got.c, bad_exp.x, bad_exp.y, bad_exp.c);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL clear_count: got %0d pixels, expected 19200", 19200 - exp_q.size());
    end
    tests_run++;
    if ({vga_plot, circ_start, busy} !== 3'b011) begin
      tests_failed++;
      $display("FAIL launch_after_clear: got plot/start/busy=%b, expected 011",
               {vga_plot, circ_start, busy});
    end
  endtask

  task automatic test_clip();
    pix_t e;
    exp_q.delete();
    tick();
    tests_run++;
    if ({circ_start, busy, vga_plot} !== 3'b110) begin
      tests_failed++;
      $display("FAIL draw_entry: got start/busy/plot=%b, expected 110", {circ_start, busy, vga_plot});
    end
    drive_pix(1'b1, 8'd159, 7'd119, 3'd5, 1'b0);
    exp_q.push_back(pix_t'{8'd159, 7'd119, 3'd5});
    tick();
    e = exp_q.pop_front();
    tests_run++;
    if (vga_plot !== 1'b1 || {vga_x, vga_y, vga_colour} !== e) begin
      tests_failed++;
      $display("FAIL clip_corner: got plot=%b (%0d,%0d,c%0d), expected plot=1 (159,119,c5)",
               vga_plot, vga_x, vga_y, vga_colour);
    end
    for (int i = 0; i < 3; i++) begin
      drive_pix(1'b1, clip_x_tab[i], clip_y_tab[i], 3'd2, 1'b0);
      tick();
      tests_run++;
      if (vga_plot !== 1'b0 || vga_x !== clip_x_tab[i] || vga_y !== clip_y_tab[i]) begin
        tests_failed++;
        $display("FAIL clip_off_%0d: got plot=%b (%0d,%0d), expected plot=0 (%0d,%0d)",
                 i, vga_plot, vga_x, vga_y, clip_x_tab[i], clip_y_tab[i]);
      end
    end
    drive_pix(1'b0, 8'd20, 7'd20, 3'd1, 1'b0);
    tick();
    tests_run++;
    if (vga_plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_plot_strobe: got vga_plot=%b, expected 0", vga_plot);
    end
    drive_pix(1'b1, 8'd5, 7'd5, 3'd6, 1'b1);
    exp_q.push_back(pix_t'{8'd5, 7'd5, 3'd6});
    tick();
    drive_pix(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    e = exp_q.pop_front();
    tests_run++;
    if (vga_plot !== 1'b1 || {vga_x, vga_y, vga_colour} !== e || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pixel: got plot=%b (%0d,%0d,c%0d) done=%b busy=%b, expected plot=1 (5,5,c6) done=1 busy=0",
               vga_plot, vga_x, vga_y, vga_colour, done, busy);
    end
    tick();
    tests_run++;
    if ({vga_plot, done, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL done_release: got plot/done/busy=%b, expected 000", {vga_plot, done, busy});
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL clip_scoreboard: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_handshake();
    int n = 0;
    int guard = 0;
    int bad = 0;
    radius = 8'd20; start = 1'b1;
    tick();
    while (circ_start !== 1'b1 && guard < 20000) begin
      if (vga_plot === 1'b1) n++;
      tick();
      guard++;
    end
    tests_run++;
    if (n != 19200) begin
      tests_failed++;
      $display("FAIL handshake_sweep: got %0d pulses, expected 19200", n);
    end
    tick();
    circ_done = 1'b1;
    tick();
    circ_done = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL handshake_done: got done=%b, expected 1", done);
    end
    repeat (10) begin
      tick();
      if (done !== 1'b1 || busy !== 1'b0 || vga_plot !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL done_hold: got %0d bad cycles of 10, expected 0", bad);
    end
    start = 1'b0;
    tick();
    tests_run++;
    if ({done, busy, circ_start} !== 3'b000) begin
      tests_failed++;
      $display("FAIL return_idle: got done/busy/start=%b, expected 000", {done, busy, circ_start});
    end
    radius = 8'd10; start = 1'b1;
    tick();
    tests_run++;
    if (circ_radius !== 8'd10 || busy !== 1'b1 || vga_plot !== 1'b1 || {vga_x, vga_y} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reaccept: got r=%0d busy=%b plot=%b (%0d,%0d), expected r=10 busy=1 plot=1 (0,0)",
               circ_radius, busy, vga_plot, vga_x, vga_y);
    end
  endtask

  task automatic test_mid_reset();
    int n = 1;
    int guard = 0;
    while (n < 1000 && guard < 2000) begin
      tick();
      if (vga_plot === 1'b1) n++;
      guard++;
    end
    tests_run++;
    if (n != 1000 || {vga_x, vga_y} !== {8'd8, 7'd39}) begin
      tests_failed++;
      $display("FAIL pixel_1000: got count=%0d (%0d,%0d), expected 1000 (8,39)", n, vga_x, vga_y);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({vga_plot, busy, circ_start, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_reset: got plot/busy/start/done=%b, expected 0000",
               {vga_plot, busy, circ_start, done});
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (vga_plot !== 1'b1 || {vga_x, vga_y} !== 15'd0) begin
      tests_failed++;
      $display("FAIL restart_first: got plot=%b (%0d,%0d), expected plot=1 (0,0)", vga_plot, vga_x, vga_y);
    end
    tick();
    tests_run++;
    if (vga_plot !== 1'b1 || {vga_x, vga_y} !== {8'd0, 7'd1}) begin
      tests_failed++;
      $display("FAIL restart_second: got plot=%b (%0d,%0d), expected plot=1 (0,1)", vga_plot, vga_x, vga_y);
    end
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_clear();
    radius = 8'd33; start2 = 1'b1;
    tests_run++;
    if (circ_start2 !== 1'b0 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL noclr_idle: got start=%b busy=%b, expected 0 0", circ_start2, busy2);
    end
    tick();
    tests_run++;
    if ({circ_start2, busy2, vga_plot2} !== 3'b110 || circ_radius2 !== 8'd33) begin
      tests_failed++;
      $display("FAIL noclr_launch: got start/busy/plot=%b r=%0d, expected 110 r=33",
               {circ_start2, busy2, vga_plot2}, circ_radius2);
    end
    tick();
    tests_run++;
    if (circ_start2 !== 1'b1 || vga_plot2 !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL noclr_draw: got start2=%b plot2=%b busy=%b, expected 1 0 0",
               circ_start2, vga_plot2, busy);
    end
    rst = 1'b1; start2 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_sweep();
    test_clip();
    test_handshake();
    test_mid_reset();
    test_no_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
